// File: rtl/tetris_pkg.sv
// Shared definitions for the 4x8 Tetris datapath: board geometry, state codes,
// piece type and the spawn footprints at anchor location 5.
package tetris_pkg;

  localparam int BOARD_W = 32;
  localparam int ROWS    = 8;
  localparam int COLS    = 4;

  localparam logic [2:0] CODE_IDLE    = 3'b000;
  localparam logic [2:0] CODE_MOVE    = 3'b001;
  localparam logic [2:0] CODE_CAPTURE = 3'b010;
  localparam logic [2:0] CODE_WAIT    = 3'b011;
  localparam logic [2:0] CODE_CLEAR   = 3'b100;
  localparam logic [2:0] CODE_SPAWN   = 3'b101;
  localparam logic [2:0] CODE_OVER    = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE    = CODE_IDLE,
    ST_MOVE    = CODE_MOVE,
    ST_CAPTURE = CODE_CAPTURE,
    ST_WAIT    = CODE_WAIT,
    ST_CLEAR   = CODE_CLEAR,
    ST_SPAWN   = CODE_SPAWN,
    ST_OVER    = CODE_OVER
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE   = 2'd0,
    REQ_LEFT   = 2'd1,
    REQ_RIGHT  = 2'd2,
    REQ_ROTATE = 2'd3
  } req_t;

  typedef logic [1:0] piece_t;

  // Footprints with the anchor on row 1 col 1 (bit 5)
  localparam logic [BOARD_W-1:0] FP_TYPE0 = 32'h0000_0020;  // {5}
  localparam logic [BOARD_W-1:0] FP_TYPE1 = 32'h0000_0022;  // {5,1}
  localparam logic [BOARD_W-1:0] FP_TYPE2 = 32'h0000_0066;  // {5,6,1,2}
  localparam logic [BOARD_W-1:0] FP_TYPE3 = 32'h0000_0062;  // {5,6,1}

  function automatic logic [BOARD_W-1:0] spawn_footprint(input piece_t t);
    logic [BOARD_W-1:0] fp;
    case (t)
      2'd0:    fp = FP_TYPE0;
      2'd1:    fp = FP_TYPE1;
      2'd2:    fp = FP_TYPE2;
      default: fp = FP_TYPE3;
    endcase
    return fp;
  endfunction

endpackage

// File: rtl/tetris_row_clear.sv
// Combinational full-row detect for one row, plus the board with that row
// removed and everything above it dropped by one row.
module tetris_row_clear
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [2:0]         row,
  output logic               row_full,
  output logic [BOARD_W-1:0] board_shifted
);

  always_comb begin
    row_full      = &board[COLS*row +: COLS];
    board_shifted = board;
    board_shifted[COLS-1:0] = '0;
    // Rows 1..row take the contents of the row above; lower rows are untouched
    for (int i = 1; i < ROWS; i++) begin
      if (i <= int'(row)) begin
        board_shifted[COLS*i +: COLS] = board[COLS*(i-1) +: COLS];
      end
    end
  end

endmodule

// File: rtl/tetris_sequencer.sv
// Game controller for the 4x8 Tetris datapath: gravity tick, move strobes,
// row clearing, spawning and game-over. Define RANDOM_PIECE_EN to draw piece
// types from a 4-bit LFSR instead of a cycling 2-bit counter.
module tetris_sequencer
  import tetris_pkg::*;
#(
  parameter int         TICK_CYCLES = 16,
  parameter int         CNT_W       = $clog2(TICK_CYCLES),
  parameter logic [4:0] SPAWN_LOC   = 5'd5
) (
  input  logic               clka,
  input  logic               restart,
  input  logic               start,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_rotate,
  input  logic               touched,
  input  logic [BOARD_W-1:0] new_board_state,
  input  logic [4:0]         new_location,
  input  logic [1:0]         new_rotation,
  output logic [2:0]         state,
  output logic               left,
  output logic               right,
  output logic               rotate,
  output logic [BOARD_W-1:0] curr_board_state,
  output logic [1:0]         curr_piece_type,
  output logic [4:0]         curr_piece_location,
  output logic [1:0]         curr_piece_rotation,
  output logic [7:0]         score,
  output logic               game_over
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BOARD_W-1:0] board_q, board_d;
  piece_t             type_q, type_d;
  logic [4:0]         loc_q, loc_d;
  logic [1:0]         rot_q, rot_d;
  logic [7:0]         score_q, score_d;
  logic [2:0]         row_q, row_d;
  req_t               req_q, req_d;
  logic [2:0]         btn_prev_q;
  logic [2:0]         btn_now, btn_rise;
  logic               accept;
  logic               gen_adv;
  piece_t             gen_type;
  logic [BOARD_W-1:0] spawn_fp;
  logic               row_full;
  logic [BOARD_W-1:0] board_shifted;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  tetris_row_clear u_row_clear (
    .board         (board_q),
    .row           (row_q),
    .row_full      (row_full),
    .board_shifted (board_shifted)
  );

  assign spawn_fp = spawn_footprint(gen_type);

  // Piece generator, advanced once per SPAWN
`ifdef RANDOM_PIECE_EN
  logic [3:0] lfsr_q;
  assign gen_type = lfsr_q[1:0];
  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      lfsr_q <= 4'b1001;
    end else if (gen_adv) begin
      lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end
  end
`else
  piece_t gen_q;
  assign gen_type = gen_q;
  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      gen_q <= '0;
    end else if (gen_adv) begin
      gen_q <= gen_q + 2'd1;
    end
  end
`endif

  // Button edges: the first request wins and is held until MOVE consumes it
  always_comb begin
    btn_now  = {btn_rotate, btn_right, btn_left};
    btn_rise = btn_now & ~btn_prev_q;
    accept   = (state_q != ST_IDLE) && (state_q != ST_OVER);
    req_d    = (state_q == ST_MOVE || state_q == ST_IDLE) ? REQ_NONE : req_q;
    if (accept && req_d == REQ_NONE) begin
      if (btn_rise[0])      req_d = REQ_LEFT;
      else if (btn_rise[1]) req_d = REQ_RIGHT;
      else if (btn_rise[2]) req_d = REQ_ROTATE;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    board_d = board_q;
    type_d  = type_q;
    loc_d   = loc_q;
    rot_d   = rot_q;
    score_d = score_q;
    row_d   = row_q;
    gen_adv = 1'b0;
    left    = 1'b0;
    right   = 1'b0;
    rotate  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SPAWN;
      end
      ST_MOVE: begin
        left    = (req_q == REQ_LEFT);
        right   = (req_q == REQ_RIGHT);
        rotate  = (req_q == REQ_ROTATE);
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        board_d = new_board_state;
        loc_d   = new_location;
        rot_d   = new_rotation;
        if (touched) begin
          state_d = ST_CLEAR;
          row_d   = 3'd7;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = ST_MOVE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_CLEAR: begin
        // A full row is removed and the same row index re-examined next cycle
        if (row_full) begin
          board_d = board_shifted;
          score_d = sat_inc(score_q);
        end else if (row_q == 3'd0) begin
          state_d = ST_SPAWN;
        end else begin
          row_d = row_q - 3'd1;
        end
      end
      ST_SPAWN: begin
        type_d  = gen_type;
        loc_d   = SPAWN_LOC;
        rot_d   = '0;
        cnt_d   = '0;
        gen_adv = 1'b1;
        if (|(board_q & spawn_fp)) begin
          state_d = ST_OVER;
        end else begin
          board_d = board_q | spawn_fp;
          state_d = ST_WAIT;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d = ST_IDLE;
          board_d = '0;
          score_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      board_q    <= '0;
      type_q     <= '0;
      loc_q      <= SPAWN_LOC;
      rot_q      <= '0;
      score_q    <= '0;
      row_q      <= 3'd7;
      req_q      <= REQ_NONE;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      board_q    <= board_d;
      type_q     <= type_d;
      loc_q      <= loc_d;
      rot_q      <= rot_d;
      score_q    <= score_d;
      row_q      <= row_d;
      req_q      <= req_d;
      btn_prev_q <= btn_now;
    end
  end

  assign state               = state_q;
  assign curr_board_state    = board_q;
  assign curr_piece_type     = type_q;
  assign curr_piece_location = loc_q;
  assign curr_piece_rotation = rot_q;
  assign score               = score_q;
  assign game_over           = (state_q == ST_OVER);

endmodule

// File: tb/tb_tetris_sequencer.sv
// Self-checking bench for tetris_sequencer; the bench plays the role of move_piece.
module tb_tetris_sequencer;

  localparam int TICK = 16;
  localparam logic [2:0] S_IDLE = 3'b000, S_MOVE = 3'b001, S_CAPTURE = 3'b010, S_WAIT = 3'b011,
                         S_CLEAR = 3'b100, S_SPAWN = 3'b101, S_OVER = 3'b110;

  logic        clka = 1'b0;
  logic        restart = 1'b1;
  logic        start = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0;
  logic        touched = 1'b0;
  logic [31:0] new_board_state = '0;
  logic [4:0]  new_location = 5'd5;
  logic [1:0]  new_rotation = '0;
  logic [2:0]  state;
  logic        left, right, rotate;
  logic [31:0] curr_board_state;
  logic [1:0]  curr_piece_type;
  logic [4:0]  curr_piece_location;
  logic [1:0]  curr_piece_rotation;
  logic [7:0]  score;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  int spawn_idx = 0;
  int exp_score = 0;

  tetris_sequencer #(.TICK_CYCLES(TICK), .CNT_W($clog2(TICK)), .SPAWN_LOC(5'd5)) dut (
    .clka(clka), .restart(restart), .start(start),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate),
    .touched(touched), .new_board_state(new_board_state),
    .new_location(new_location), .new_rotation(new_rotation),
    .state(state), .left(left), .right(right), .rotate(rotate),
    .curr_board_state(curr_board_state), .curr_piece_type(curr_piece_type),
    .curr_piece_location(curr_piece_location), .curr_piece_rotation(curr_piece_rotation),
    .score(score), .game_over(game_over)
  );

  always #5 clka = ~clka;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] footprint(input int t);
    logic [31:0] m;
    m = '0;
    m[5] = 1'b1;
    if (t == 1 || t == 2 || t == 3) m[1] = 1'b1;
    if (t == 2 || t == 3) m[6] = 1'b1;
    if (t == 2) m[2] = 1'b1;
    return m;
  endfunction

  function automatic int type_at(input int idx);
`ifdef RANDOM_PIECE_EN
    logic [3:0] s;
    s = 4'b1001;
    for (int k = 0; k < idx; k++) s = {s[2:0], s[3] ^ s[2]};
    return int'(s[1:0]);
`else
    return idx % 4;
`endif
  endfunction

  // Drop every full row and let the survivors settle to the bottom
  function automatic logic [31:0] clear_model(input logic [31:0] b, output int nfull);
    logic [3:0]  kept[$];
    logic [31:0] res;
    nfull = 0;
    for (int r = 7; r >= 0; r--) begin
      if (b[4*r +: 4] == 4'hF) nfull++;
      else kept.push_back(b[4*r +: 4]);
    end
    res = '0;
    for (int i = 0; i < kept.size(); i++) res[4*(7-i) +: 4] = kept[i];
    return res;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic to_state(input logic [2:0] code, input int maxc, output bit ok, output int n);
    n = 0;
    while (state !== code && n < maxc) begin
      tick();
      n++;
    end
    ok = (state === code);
  endtask

  task automatic do_capture(input logic t, input logic [31:0] b, input logic [4:0] loc, input logic [1:0] rot);
    touched = t; new_board_state = b; new_location = loc; new_rotation = rot;
    tick();
    touched = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 restart = 1'b0;
    #20;
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", state, S_IDLE); end
    checks++; if (curr_board_state !== 32'h0) begin errors++; $display("FAIL reset_board: got %h required 0", curr_board_state); end
    checks++; if (curr_piece_type !== 2'd0) begin errors++; $display("FAIL reset_type: got %0d required 0", curr_piece_type); end
    checks++; if (curr_piece_location !== 5'd5) begin errors++; $display("FAIL reset_loc: got %0d required 5", curr_piece_location); end
    checks++; if (curr_piece_rotation !== 2'd0) begin errors++; $display("FAIL reset_rot: got %0d required 0", curr_piece_rotation); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d required 0", score); end
    checks++; if ({rotate, right, left} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b required 000", {rotate, right, left}); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b required 0", game_over); end
    tick();
    restart = 1'b1;
  endtask

  task automatic test_spawn_tick();
    int n;
    logic [31:0] fp;
    start = 1'b1;
    tick();
    checks++; if (state !== S_SPAWN) begin errors++; $display("FAIL start_spawn: got %0d required %0d", state, S_SPAWN); end
    start = 1'b0;
    tick();
    fp = footprint(type_at(0));
    checks++; if (state !== S_WAIT) begin errors++; $display("FAIL spawn_wait: got %0d required %0d", state, S_WAIT); end
    checks++; if (curr_board_state !== fp) begin errors++; $display("FAIL spawn_board: got %h required %h", curr_board_state, fp); end
    checks++; if (curr_piece_type !== 2'(type_at(0))) begin errors++; $display("FAIL spawn_type: got %0d required %0d", curr_piece_type, type_at(0)); end
    checks++; if (curr_piece_location !== 5'd5 || curr_piece_rotation !== 2'd0) begin errors++; $display("FAIL spawn_pose: got loc %0d rot %0d required 5 0", curr_piece_location, curr_piece_rotation); end
    spawn_idx = 1;
    n = 0;
    while (state === S_WAIT && n < 100) begin tick(); n++; end
    checks++; if (state !== S_MOVE) begin errors++; $display("FAIL tick_move: got %0d required %0d", state, S_MOVE); end
    checks++; if (n != TICK) begin errors++; $display("FAIL tick_length: got %0d required %0d", n, TICK); end
  endtask

  task automatic test_buttons();
    int n, pend, bad;
    bit ok;
    logic [2:0] prev, v, rise, exp;
    logic [4:0] loc;
    logic [1:0] rot;
    tick();
    checks++; if (state !== S_CAPTURE) begin errors++; $display("FAIL move_capture: got %0d required %0d", state, S_CAPTURE); end
    do_capture(1'b0, 32'h0000_0020, 5'd9, 2'd1);
    checks++; if (curr_piece_location !== 5'd9 || curr_piece_rotation !== 2'd1) begin errors++; $display("FAIL capture_pose: got loc %0d rot %0d required 9 1", curr_piece_location, curr_piece_rotation); end
    checks++; if (state !== S_WAIT) begin errors++; $display("FAIL capture_wait: got %0d required %0d", state, S_WAIT); end
    tick(); btn_left = 1'b1; tick(); btn_left = 1'b0; tick(); btn_right = 1'b1; tick(); btn_right = 1'b0;
    bad = 0; n = 0;
    while (state !== S_MOVE && n < 40) begin
      if ({rotate, right, left} !== 3'b000) bad++;
      tick(); n++;
    end
    checks++; if (state !== S_MOVE) begin errors++; $display("FAIL tap_move: got %0d required %0d", state, S_MOVE); end
    checks++; if ({rotate, right, left} !== 3'b001) begin errors++; $display("FAIL tap_left_strobe: got %b required 001", {rotate, right, left}); end
    checks++; if (bad != 0) begin errors++; $display("FAIL strobe_outside_move: got %0d cycles required 0", bad); end
    tick();
    checks++; if ({rotate, right, left} !== 3'b000) begin errors++; $display("FAIL strobe_after_move: got %b required 000", {rotate, right, left}); end
    do_capture(1'b0, 32'h0000_0020, 5'd5, 2'd0);
    to_state(S_MOVE, 40, ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL next_tick_timeout: state %0d required %0d", state, S_MOVE); end
    checks++; if ({rotate, right, left} !== 3'b000) begin errors++; $display("FAIL next_tick_strobe: got %b required 000", {rotate, right, left}); end

    for (int it = 0; it < 8; it++) begin
      tick();
      loc = 5'($urandom_range(0, 31));
      rot = 2'($urandom_range(0, 3));
      do_capture(1'b0, 32'h0000_0020, loc, rot);
      checks++; if (curr_piece_location !== loc || curr_piece_rotation !== rot) begin errors++; $display("FAIL rand_capture_pose: got loc %0d rot %0d required %0d %0d", curr_piece_location, curr_piece_rotation, loc, rot); end
      prev = 3'b000; pend = 0; n = 0;
      while (state === S_WAIT && n < 100) begin
        if ($urandom_range(0, 2) == 0) v = 3'($urandom_range(0, 7));
        else v = prev;
        {btn_rotate, btn_right, btn_left} = v;
        rise = v & ~prev;
        if (pend == 0) begin
          if (rise[0]) pend = 1;
          else if (rise[1]) pend = 2;
          else if (rise[2]) pend = 3;
        end
        prev = v;
        tick(); n++;
      end
      {btn_rotate, btn_right, btn_left} = 3'b000;
      exp = (pend == 0) ? 3'b000 : 3'(1 << (pend - 1));
      checks++; if (state !== S_MOVE) begin errors++; $display("FAIL rand_move: got %0d required %0d", state, S_MOVE); end
      checks++; if ({rotate, right, left} !== exp) begin errors++; $display("FAIL rand_strobe: got %b required %b", {rotate, right, left}, exp); end
    end
  endtask

  task automatic test_clear();
    logic [31:0] b, want;
    int nfull, n;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) b = 32'hFF00_0A60;
      else begin
        b = '0;
        for (int r = 2; r < 8; r++) b[4*r +: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 14));
      end
      to_state(S_MOVE, 40, ok, n);
      checks++; if (!ok) begin errors++; $display("FAIL clear_move_timeout: state %0d required %0d", state, S_MOVE); end
      tick();
      do_capture(1'b1, b, 5'd5, 2'd0);
      want = clear_model(b, nfull);
      n = 0;
      while (state === S_CLEAR && n < 40) begin tick(); n++; end
      exp_score = sat_add(exp_score, nfull);
      checks++; if (state !== S_SPAWN) begin errors++; $display("FAIL clear_spawn: got %0d required %0d", state, S_SPAWN); end
      checks++; if (n != 8 + nfull) begin errors++; $display("FAIL clear_cycles: got %0d required %0d", n, 8 + nfull); end
      checks++; if (curr_board_state !== want) begin errors++; $display("FAIL clear_board: got %h required %h", curr_board_state, want); end
      checks++; if (score !== 8'(exp_score)) begin errors++; $display("FAIL clear_score: got %0d required %0d", score, exp_score); end
      tick();
      want = want | footprint(type_at(spawn_idx));
      checks++; if (state !== S_WAIT || curr_board_state !== want) begin errors++; $display("FAIL clear_respawn: got state %0d board %h required %0d %h", state, curr_board_state, S_WAIT, want); end
      checks++; if (curr_piece_type !== 2'(type_at(spawn_idx))) begin errors++; $display("FAIL clear_type: got %0d required %0d", curr_piece_type, type_at(spawn_idx)); end
      spawn_idx++;
    end
  endtask

  task automatic test_over();
    int n;
    bit ok;
    to_state(S_MOVE, 40, ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL over_move_timeout: state %0d required %0d", state, S_MOVE); end
    tick();
    do_capture(1'b1, 32'h0000_0022, 5'd5, 2'd0);
    to_state(S_OVER, 30, ok, n);
    spawn_idx++;
    checks++; if (!ok) begin errors++; $display("FAIL over_timeout: state %0d required %0d", state, S_OVER); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL over_flag: got %b required 1", game_over); end
    checks++; if (curr_board_state !== 32'h0000_0022) begin errors++; $display("FAIL over_board: got %h required 00000022", curr_board_state); end
    checks++; if (curr_piece_type !== 2'(type_at(spawn_idx - 1))) begin errors++; $display("FAIL over_type: got %0d required %0d", curr_piece_type, type_at(spawn_idx - 1)); end
    btn_left = 1'b1;
    repeat (3) tick();
    btn_left = 1'b0;
    checks++; if (state !== S_OVER || curr_board_state !== 32'h0000_0022) begin errors++; $display("FAIL over_hold: got state %0d board %h required %0d 00000022", state, curr_board_state, S_OVER); end
    start = 1'b1;
    tick();
    exp_score = 0;
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL over_idle: got %0d required %0d", state, S_IDLE); end
    checks++; if (curr_board_state !== 32'h0 || score !== 8'd0 || game_over !== 1'b0) begin errors++; $display("FAIL idle_clear: got board %h score %0d go %b required 0 0 0", curr_board_state, score, game_over); end
    tick();
    start = 1'b0;
    checks++; if (state !== S_SPAWN) begin errors++; $display("FAIL restart_spawn: got %0d required %0d", state, S_SPAWN); end
    tick();
    checks++; if (curr_board_state !== footprint(type_at(spawn_idx)) || curr_piece_type !== 2'(type_at(spawn_idx))) begin errors++; $display("FAIL restart_piece: got board %h type %0d required %h %0d", curr_board_state, curr_piece_type, footprint(type_at(spawn_idx)), type_at(spawn_idx)); end
    spawn_idx++;
  endtask

  task automatic test_score_saturate();
    int n;
    bit ok;
    for (int it = 0; it < 44; it++) begin
      to_state(S_MOVE, 40, ok, n);
      checks++; if (!ok) begin errors++; $display("FAIL sat_move_timeout: state %0d required %0d", state, S_MOVE); end
      tick();
      do_capture(1'b1, 32'hFFFF_FF00, 5'd5, 2'd0);
      to_state(S_SPAWN, 30, ok, n);
      exp_score = sat_add(exp_score, 6);
      checks++; if (score !== 8'(exp_score)) begin errors++; $display("FAIL sat_score: got %0d required %0d", score, exp_score); end
      tick();
      spawn_idx++;
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit ok;
    to_state(S_MOVE, 40, ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL areset_move_timeout: state %0d required %0d", state, S_MOVE); end
    tick();
    do_capture(1'b1, 32'hFFFF_0000, 5'd5, 2'd0);
    checks++; if (state !== S_CLEAR) begin errors++; $display("FAIL areset_in_clear: got %0d required %0d", state, S_CLEAR); end
    tick(); tick();
    #3 restart = 1'b0;
    #1;
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL areset_state: got %0d required %0d", state, S_IDLE); end
    checks++; if (curr_board_state !== 32'h0) begin errors++; $display("FAIL areset_board: got %h required 0", curr_board_state); end
    checks++; if (curr_piece_type !== 2'd0 || curr_piece_location !== 5'd5 || curr_piece_rotation !== 2'd0) begin errors++; $display("FAIL areset_piece: got %0d %0d %0d required 0 5 0", curr_piece_type, curr_piece_location, curr_piece_rotation); end
    checks++; if (score !== 8'd0 || game_over !== 1'b0 || {rotate, right, left} !== 3'b000) begin errors++; $display("FAIL areset_misc: got score %0d go %b strobes %b required 0 0 000", score, game_over, {rotate, right, left}); end
    spawn_idx = 0;
    exp_score = 0;
    tick();
    restart = 1'b1;
  endtask

  task automatic test_piece_sequence();
    logic [1:0] got[4];
    int n;
    bit ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    got[0] = curr_piece_type;
    for (int k = 1; k < 4; k++) begin
      to_state(S_MOVE, 40, ok, n);
      tick();
      do_capture(1'b1, 32'h0, 5'd5, 2'd0);
      to_state(S_WAIT, 30, ok, n);
      checks++; if (!ok) begin errors++; $display("FAIL seq_spawn_timeout: state %0d required %0d", state, S_WAIT); end
      got[k] = curr_piece_type;
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== 2'(type_at(k))) begin errors++; $display("FAIL seq_type%0d: got %0d required %0d", k, got[k], type_at(k)); end
    end
    spawn_idx = 4;
  endtask

  initial begin
    test_reset();
    test_spawn_tick();
    test_buttons();
    test_clear();
    test_over();
    test_score_saturate();
    test_async_reset();
    test_piece_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
